inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//   Instruction fetch stage: owns the PC, issues requests to instruction memory and buffers returned words.
//   Delivers {inst, pc} to the decode stage and accepts redirects from the control logic.
//   Redirects are driven by IF_flush / pc_sel with the ALU-computed target.
//   Sits between imem and decode; decode consumes id_inst and drives back IF_flush, pc_sel and alu_target.
// PARAMETERS
//   PC_WIDTH    32             PC / address width
//   INST_WIDTH  32             instruction width
//   RESET_PC    32'h0000_0000  PC after reset; low 2 bits must be 0
//   SLOT_DEPTH  2              fetch slots (outstanding requests + buffered words); power of 2, >=2
// PORTS
//   clk             in   1           single clock, rising edge
//   reset           in   1           synchronous, active-high
//   IF_flush        in   1           kill all fetched/in-flight instructions
//   pc_sel          in   1           1 = take alu_target
//   alu_target      in   PC_WIDTH    redirect target
//   imem_req_valid  out  1           fetch request valid
//   imem_req_ready  in   1           imem accepts request
//   imem_req_addr   out  PC_WIDTH    word-aligned fetch address
//   imem_rsp_valid  in   1           response data valid; in order, one per accepted request
//   imem_rsp_data   in   INST_WIDTH  fetched instruction
//   id_valid        out  1           id_inst/id_pc valid to decode
//   id_ready        in   1           decode consumes this cycle
//   id_inst         out  INST_WIDTH  instruction to decode
//   id_pc           out  PC_WIDTH    PC of id_inst
// BEHAVIOUR
//   Reset values (take effect on the next edge):
//     pc_q = RESET_PC; imem_req_valid = 0; id_valid = 0; id_inst = NOP (32'h0000_0013);
//     id_pc = RESET_PC; all slots free; drop_cnt = 0.
//   Slot allocation:
//     A slot is allocated, holding the pc, when a request is accepted (imem_req_valid & imem_req_ready).
//     The slot is filled on the next undropped imem_rsp_valid, in order.
//     The slot is freed when the head is filled and id_valid & id_ready.
//   Request issue:
//     imem_req_valid = 1 when a free slot exists and no redirect this cycle.
//     imem_req_addr = pc_q, held stable while valid & !ready.
//     On accept: pc_q <= pc_q + 4 (wraps mod 2^PC_WIDTH).
//     Minimum imem latency is 1 cycle; no combinational rsp-from-req path is required.
//   Delivery:
//     id_valid = head slot allocated and filled.
//     Outputs are stable while id_valid & !id_ready.
//     Push and pop in the same cycle are legal when full; a freed slot is reusable on the next cycle only.
//   Redirect (redirect = IF_flush | pc_sel), registered behaviour:
//     pc_q <= {alu_target[PC_WIDTH-1:2], 2'b00}; misaligned low bits are silently cleared.
//     All slots are freed, and id_valid = 0 in the following cycle.
//     drop_cnt <= allocated-unfilled slots + (request accepted this cycle) - (response arriving this cycle).
//     The request may be withdrawn in the redirect cycle (the only legal withdrawal).
//     Fetch resumes from the target on the next cycle.
//   Response dropping:
//     While drop_cnt > 0, each imem_rsp_valid is discarded and decrements drop_cnt.
//     New requests may issue during the drop; their responses are ordered after the dropped ones.
//   Overlapping redirects:
//     A redirect while drop_cnt > 0 accumulates onto drop_cnt.
//     drop_cnt is sized log2(SLOT_DEPTH)+1 bits and never exceeds SLOT_DEPTH.
//   reset overrides redirect and any handshake in the same cycle; in-flight responses after reset are
//     the environment's responsibility (imem is reset together).
// CONFIGURATION
//   IF_PERF_CNT_EN defined:
//     Adds out ports fetch_cnt[31:0] (accepted requests) and flush_cnt[31:0] (redirect cycles).
//     Both reset to 0, saturate at 32'hFFFF_FFFF.
//   IF_PERF_CNT_EN undefined:
//     The ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//   Shared defines header (risc_v_defines.vh): PC_WIDTH, INST_WIDTH, RESET_PC, NOP_INST (32'h0000_0013).
//   Sub-module fetch_slot_queue: circular slot array {pc, inst, filled}, with alloc / fill / pop / clear ports,
//     plus head/tail/fill pointers.
//   Top level holds pc_q, drop_cnt, request logic and the optional counters.
// TESTING
//   1. Reset, imem ready always, 1-cycle latency, id_ready=1 ->
//      id_pc sequence 0x0,0x4,0x8..., one instruction per cycle in steady state.
//   2. id_ready=0 for 5 cycles with SLOT_DEPTH=2 ->
//      At most 2 requests issued; id_inst/id_pc frozen; resumes with no loss or duplication.
//   3. IF_flush=1, pc_sel=1, alu_target=0x103 with 2 requests in flight ->
//      Next imem_req_addr=0x100; 2 responses dropped; first id_pc=0x100.
//   4. imem_req_ready=0 for 3 cycles ->
//      imem_req_addr stable at 0x8 and imem_req_valid stays 1 throughout.
//   5. Redirect in the same cycle as imem_rsp_valid and request accept ->
//      drop_cnt correct (in-flight+1-1); no stale instruction reaches decode.
//   6. Back-to-back redirects to 0x40 then 0x80 ->
//      Only 0x80 stream delivered.
//      With IF_PERF_CNT_EN: flush_cnt=2 and fetch_cnt equals the accepted-request count.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage constants: default widths, reset PC and the NOP encoding.
// Imported by the fetch unit and its slot queue.
// Build option: IF_PERF_CNT_EN enables the fetch/flush performance counters in the top.
package inst_fetch_unit_pkg;

    localparam int          DEF_PC_WIDTH   = 32;
    localparam int          DEF_INST_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_unit_fetch_slot_queue.sv
// Circular array of fetch slots {pc, inst, filled}: allocated on request accept, filled in order
// by responses, popped at the head by decode. Head is visible combinationally from registers (0 cycles).
// No internal backpressure: the owner must not allocate when full or fill with nothing outstanding.
module inst_fetch_unit_fetch_slot_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int                   SLOT_DEPTH = 2,
    parameter int                   PC_WIDTH   = DEF_PC_WIDTH,
    parameter int                   INST_WIDTH = DEF_INST_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = DEF_RESET_PC[PC_WIDTH-1:0],
    parameter logic [INST_WIDTH-1:0] RESET_INST = NOP_INST[INST_WIDTH-1:0],
    localparam int                  AW         = $clog2(SLOT_DEPTH),
    localparam int                  CW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  alloc_i,
    input  logic [PC_WIDTH-1:0]   alloc_pc_i,
    input  logic                  fill_i,
    input  logic [INST_WIDTH-1:0] fill_inst_i,
    input  logic                  pop_i,
    output logic                  head_vld_o,
    output logic [PC_WIDTH-1:0]   head_pc_o,
    output logic [INST_WIDTH-1:0] head_inst_o,
    output logic [CW-1:0]         alloc_cnt_o,
    output logic [CW-1:0]         unfilled_cnt_o
);

    logic [PC_WIDTH-1:0]   pc_q     [SLOT_DEPTH];
    logic [INST_WIDTH-1:0] inst_q   [SLOT_DEPTH];
    logic [SLOT_DEPTH-1:0] filled_q;
    logic [AW-1:0]         head_q;
    logic [AW-1:0]         tail_q;
    logic [AW-1:0]         fill_ptr_q;
    logic [CW-1:0]         alloc_cnt_q;
    logic [CW-1:0]         unfilled_cnt_q;

    // Slot storage and the three ring pointers; clear drops every slot but keeps stale payloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            fill_ptr_q     <= '0;
            alloc_cnt_q    <= '0;
            unfilled_cnt_q <= '0;
            filled_q       <= '0;
            for (int i = 0; i < SLOT_DEPTH; i++) begin
                pc_q[i]   <= RESET_PC;
                inst_q[i] <= RESET_INST;
            end
        end else if (clear_i) begin
            head_q         <= '0;
            tail_q         <= '0;
            fill_ptr_q     <= '0;
            alloc_cnt_q    <= '0;
            unfilled_cnt_q <= '0;
            filled_q       <= '0;
        end else begin
            // Alloc and fill never hit the same slot: fill only targets already-allocated slots,
            // and alloc is blocked when the ring is full.
            if (alloc_i) begin
                pc_q[tail_q]     <= alloc_pc_i;
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + AW'(1);
            end
            if (fill_i) begin
                inst_q[fill_ptr_q]   <= fill_inst_i;
                filled_q[fill_ptr_q] <= 1'b1;
                fill_ptr_q           <= fill_ptr_q + AW'(1);
            end
            if (pop_i) begin
                head_q <= head_q + AW'(1);
            end
            alloc_cnt_q    <= alloc_cnt_q + CW'(alloc_i) - CW'(pop_i);
            unfilled_cnt_q <= unfilled_cnt_q + CW'(alloc_i) - CW'(fill_i);
        end
    end

    // Head slot is deliverable once it is both allocated and filled.
    always_comb begin
        head_vld_o     = (alloc_cnt_q != '0) && filled_q[head_q];
        head_pc_o      = pc_q[head_q];
        head_inst_o    = inst_q[head_q];
        alloc_cnt_o    = alloc_cnt_q;
        unfilled_cnt_o = unfilled_cnt_q;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches to imem, buffers words for decode, handles redirects.
// Latency: a response is visible to decode the cycle after it arrives; redirects take effect next cycle.
// Backpressure: requests stall when all slots (live + still-to-be-dropped) are used; decode stalls hold id_*.
// Build option IF_PERF_CNT_EN adds the fetch_cnt / flush_cnt performance counter ports.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH   = DEF_PC_WIDTH,
    parameter int                  INST_WIDTH = DEF_INST_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = DEF_RESET_PC[PC_WIDTH-1:0],
    parameter int                  SLOT_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IF_flush,
    input  logic                  pc_sel,
    input  logic [PC_WIDTH-1:0]   alu_target,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [PC_WIDTH-1:0]   id_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam int AW = $clog2(SLOT_DEPTH);
    localparam int CW = AW + 1;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [CW-1:0]       drop_cnt_q;
    logic [CW-1:0]       drop_cnt_d;
    logic [CW-1:0]       alloc_cnt;
    logic [CW-1:0]       unfilled_cnt;
    logic                redirect;
    logic                has_space;
    logic                req_fire;
    logic                rsp_fill;
    logic                rsp_drop;
    logic                id_fire;

    // Request side: responses still to be dropped occupy capacity exactly like live slots, which
    // keeps total outstanding responses (and therefore drop_cnt) bounded by SLOT_DEPTH.
    always_comb begin
        redirect       = IF_flush | pc_sel;
        has_space      = (alloc_cnt + drop_cnt_q) < CW'(SLOT_DEPTH);
        imem_req_valid = !reset && !redirect && has_space;
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
        rsp_fill       = imem_rsp_valid && (drop_cnt_q == '0);
        id_fire        = id_valid && id_ready;
    end

    // Next PC: a redirect wins over sequential advance; the target is forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = alu_target & ~PC_WIDTH'(3);
        end else if (req_fire) begin
            pc_d = pc_q + PC_WIDTH'(4);
        end
    end

    // Drop counter: on a redirect every response not yet matched to a filled slot becomes a drop,
    // net of the response consumed this cycle (whether it was itself a drop or a fill).
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = drop_cnt_q + unfilled_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
        end else if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    // PC and drop counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    inst_fetch_unit_fetch_slot_queue #(
        .SLOT_DEPTH (SLOT_DEPTH),
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .RESET_PC   (RESET_PC),
        .RESET_INST (NOP_INST[INST_WIDTH-1:0])
    ) u_slots (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (redirect),
        .alloc_i        (req_fire),
        .alloc_pc_i     (pc_q),
        .fill_i         (rsp_fill),
        .fill_inst_i    (imem_rsp_data),
        .pop_i          (id_fire),
        .head_vld_o     (id_valid),
        .head_pc_o      (id_pc),
        .head_inst_o    (id_inst),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counters of accepted requests and redirect cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (req_fire && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: cycle table for startup/stall/redirect, directed corner sequences,
// and a randomized run checked against a stream-level model (in-order program from last redirect target).
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_flush, pc_sel;
    logic [31:0] alu_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid, id_ready;
    logic [31:0] id_inst, id_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .IF_flush       (IF_flush),
        .pc_sel         (pc_sel),
        .alu_target     (alu_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents: an arbitrary injective function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- stream-level reference model ----------------
    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    logic [31:0] exp_pc;
    int          cyc, deliv_cnt, acc_cnt, flush_seen;
    logic [31:0] last_pc;
    bit          p_req_hold, p_id_hold;
    logic [31:0] p_addr, p_id_pc, p_id_inst;
    bit          s_rv, s_idv;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic idle_inputs();
        IF_flush       = 1'b0;
        pc_sel         = 1'b0;
        alu_target     = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_id_pc", id_pc, 32'h0);
        reset = 1'b0;
        pend_addr.delete();
        pend_cyc.delete();
        exp_pc     = 32'h0;
        p_req_hold = 0;
        p_id_hold  = 0;
        cyc        = 0;
        acc_cnt    = 0;
        flush_seen = 0;
    endtask

    // One cycle: imem model answers in order with latency >= 1, scoreboard checks decode stream.
    task automatic step(input bit rr, input bit rsp_en, input bit ir,
                        input bit fl, input bit ps, input logic [31:0] tgt);
        bit redir;
        @(negedge clk);
        imem_req_ready = rr;
        id_ready       = ir;
        IF_flush       = fl;
        pc_sel         = ps;
        alu_target     = tgt;
        if (rsp_en && pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        redir  = fl | ps;
        s_rv   = imem_req_valid;
        s_addr = imem_req_addr;
        s_idv  = id_valid;
        s_pc   = id_pc;
        s_inst = id_inst;
        if (p_req_hold && !redir) begin
            chk("req_hold_valid", {31'b0, s_rv}, 32'd1);
            chk("req_hold_addr", s_addr, p_addr);
        end
        if (p_id_hold) begin
            chk("id_hold_valid", {31'b0, s_idv}, 32'd1);
            chk("id_hold_pc", s_pc, p_id_pc);
            chk("id_hold_inst", s_inst, p_id_inst);
        end
        if (s_idv && ir) begin
            chk("id_pc_stream", s_pc, exp_pc);
            chk("id_inst_stream", s_inst, mem_word(exp_pc));
            exp_pc  = exp_pc + 32'd4;
            last_pc = s_pc;
            deliv_cnt++;
        end
        if (imem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
        end
        if (s_rv && rr) begin
            pend_addr.push_back(s_addr);
            pend_cyc.push_back(cyc);
            acc_cnt++;
            chk("outstanding_le_depth", {31'b0, pend_addr.size() <= DEPTH}, 32'd1);
        end
        if (redir) begin
            exp_pc = tgt & ~32'h3;
            flush_seen++;
        end
        p_req_hold = s_rv && !rr && !redir;
        p_addr     = s_addr;
        p_id_hold  = s_idv && !ir && !redir;
        p_id_pc    = s_pc;
        p_id_inst  = s_inst;
        cyc++;
    endtask

    // Run normal cycles until a new instruction is delivered; returns 0 on timeout.
    task automatic run_to_delivery(input int budget, output bit got, output logic [31:0] pc);
        int start;
        start = deliv_cnt;
        got   = 0;
        pc    = '0;
        for (int i = 0; i < budget && !got; i++) begin
            step(1, 1, 1, 0, 0, 32'h0);
            if (deliv_cnt != start) begin
                got = 1;
                pc  = last_pc;
            end
        end
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        bit          rr;
        bit          rv;
        logic [31:0] rsp_addr;
        bit          ir;
        bit          fl;
        bit          ps;
        logic [31:0] tgt;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_idv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit rr, input bit rv, input logic [31:0] ra, input bit ir,
                       input bit fl, input bit ps, input logic [31:0] tgt,
                       input bit e_rv, input logic [31:0] e_addr, input bit e_idv, input logic [31:0] e_pc);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rsp_addr = ra; v.ir = ir; v.fl = fl; v.ps = ps; v.tgt = tgt;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_idv = e_idv; v.e_pc = e_pc;
        vt.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        logic [31:0] fpc;
        int          base;

        reset     = 1'b1;
        deliv_cnt = 0;
        idle_inputs();

        //   rr rv rsp    ir fl ps tgt      | vld addr    idv pc
        add(1, 0, 32'h0,   1, 0, 0, 32'h0,    1, 32'h0,   0, 32'h0);
        add(1, 1, 32'h0,   1, 0, 0, 32'h0,    1, 32'h4,   0, 32'h0);
        add(1, 1, 32'h4,   1, 0, 0, 32'h0,    0, 32'h8,   1, 32'h0);
        add(1, 0, 32'h0,   1, 0, 0, 32'h0,    1, 32'h8,   1, 32'h4);
        add(1, 1, 32'h8,   1, 0, 0, 32'h0,    1, 32'hC,   0, 32'h0);
        add(1, 1, 32'hC,   1, 0, 0, 32'h0,    0, 32'h10,  1, 32'h8);
        add(0, 0, 32'h0,   0, 0, 0, 32'h0,    1, 32'h10,  1, 32'hC);
        add(0, 0, 32'h0,   0, 0, 0, 32'h0,    1, 32'h10,  1, 32'hC);
        add(1, 0, 32'h0,   0, 0, 0, 32'h0,    1, 32'h10,  1, 32'hC);
        add(1, 1, 32'h10,  0, 0, 0, 32'h0,    0, 32'h14,  1, 32'hC);
        add(1, 0, 32'h0,   0, 0, 0, 32'h0,    0, 32'h14,  1, 32'hC);
        add(1, 0, 32'h0,   1, 0, 0, 32'h0,    0, 32'h14,  1, 32'hC);
        add(1, 0, 32'h0,   1, 0, 0, 32'h0,    1, 32'h14,  1, 32'h10);
        add(1, 1, 32'h14,  1, 1, 1, 32'h103,  0, 32'h18,  0, 32'h0);
        add(1, 0, 32'h0,   1, 0, 0, 32'h0,    1, 32'h100, 0, 32'h0);
        add(1, 1, 32'h100, 1, 0, 0, 32'h0,    1, 32'h104, 0, 32'h0);
        add(1, 1, 32'h104, 1, 0, 0, 32'h0,    0, 32'h108, 1, 32'h100);

        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            imem_req_ready = vt[i].rr;
            imem_rsp_valid = vt[i].rv;
            imem_rsp_data  = mem_word(vt[i].rsp_addr);
            id_ready       = vt[i].ir;
            IF_flush       = vt[i].fl;
            pc_sel         = vt[i].ps;
            alu_target     = vt[i].tgt;
            #1;
            chk($sformatf("tbl%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vt[i].e_rv});
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
            chk($sformatf("tbl%0d_id_valid", i), {31'b0, id_valid}, {31'b0, vt[i].e_idv});
            if (vt[i].e_idv) begin
                chk($sformatf("tbl%0d_id_pc", i), id_pc, vt[i].e_pc);
                chk($sformatf("tbl%0d_id_inst", i), id_inst, mem_word(vt[i].e_pc));
            end
        end

        // Redirect to a misaligned target with two requests in flight.
        do_reset();
        step(1, 0, 0, 0, 0, 32'h0);
        chk("t3_first_req_valid", {31'b0, s_rv}, 32'd1);
        step(1, 0, 0, 0, 0, 32'h0);
        chk("t3_inflight", pend_addr.size(), 32'd2);
        step(1, 0, 1, 1, 1, 32'h103);
        chk("t3_withdrawn", {31'b0, s_rv}, 32'd0);
        step(0, 0, 1, 0, 0, 32'h0);
        chk("t3_next_addr", s_addr, 32'h100);
        run_to_delivery(40, got, fpc);
        chk("t3_delivered", {31'b0, got}, 32'd1);
        chk("t3_first_pc", fpc, 32'h100);

        // Decode stall for 5 cycles: bounded issue, frozen outputs, no loss afterwards.
        do_reset();
        repeat (6) step(1, 1, 1, 0, 0, 32'h0);
        base = acc_cnt;
        repeat (5) step(1, 1, 0, 0, 0, 32'h0);
        chk("t2_stall_accepts_le2", {31'b0, (acc_cnt - base) <= DEPTH}, 32'd1);
        base = deliv_cnt;
        repeat (20) step(1, 1, 1, 0, 0, 32'h0);
        chk("t2_resumed", {31'b0, deliv_cnt > base + 5}, 32'd1);

        // Back-to-back redirects: only the second target's stream survives.
        do_reset();
        repeat (4) step(1, 1, 1, 0, 0, 32'h0);
        step(1, 1, 1, 1, 0, 32'h40);
        step(1, 1, 1, 0, 1, 32'h80);
        run_to_delivery(40, got, fpc);
        chk("t6_delivered", {31'b0, got}, 32'd1);
        chk("t6_first_pc", fpc, 32'h80);
        step(0, 0, 0, 0, 0, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("t6_flush_cnt", flush_cnt, 32'd2);
        chk("t6_fetch_cnt", fetch_cnt, acc_cnt);
`endif

        // Randomized traffic with random redirects (some misaligned, some near the wrap point).
        do_reset();
        base = deliv_cnt;
        for (int i = 0; i < 3000; i++) begin
            bit          rr, re, ir, fl, ps;
            logic [31:0] tgt;
            rr = ($urandom_range(0, 99) < 75);
            re = ($urandom_range(0, 99) < 70);
            ir = ($urandom_range(0, 99) < 70);
            fl = 0;
            ps = 0;
            if ($urandom_range(0, 99) < 4) begin
                case ($urandom_range(0, 2))
                    0:       fl = 1;
                    1:       ps = 1;
                    default: begin fl = 1; ps = 1; end
                endcase
            end
            tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(rr, re, ir, fl, ps, tgt);
        end
        repeat (50) step(1, 1, 1, 0, 0, 32'h0);
        chk("rand_progress", {31'b0, (deliv_cnt - base) > 200}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
